// File: rtl/rv_pkg.sv
// Shared encodings for the fetch-stage PC controller: BCU redirect flag values
// and the fetch FSM state type.
package rv_pkg;

   // 2-bit redirect flag produced by the branch control unit
   localparam logic [1:0] BR_SEQ   = 2'b00;
   localparam logic [1:0] BR_TAKEN = 2'b01;
   localparam logic [1:0] BR_JALR  = 2'b10;
   localparam logic [1:0] BR_SYS   = 2'b11;

   // Fetch FSM states
   typedef enum logic [1:0] {
      RUN  = 2'd0,
      HALT = 2'd1,
      TRAP = 2'd2
   } state_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection for the fetch stage: resolves the redirect target from the
// BCU flag, flags misaligned targets, and forms the sequential/stalled PC.
module pc_next_sel
   import rv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      i_flag,
   input  logic [XLEN-1:0] i_br_target,
   input  logic [XLEN-1:0] i_jalr_target,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_stall,
   output logic [XLEN-1:0] o_tgt,
   output logic            o_misalign,
   output logic            o_redirect,
   output logic [XLEN-1:0] o_seq_pc
);

   logic w_is_br;

   // Target mux, alignment check and the non-redirect PC (hold on stall, else +4)
   always_comb begin
      w_is_br    = (i_flag == BR_TAKEN) || (i_flag == BR_JALR);
      o_tgt      = (i_flag == BR_TAKEN) ? i_br_target
                                        : {i_jalr_target[XLEN-1:1], 1'b0};
      // bit0 is always clear here, so only bit1 can make the target non-word-aligned
      o_misalign = w_is_br && o_tgt[1];
      o_redirect = w_is_br && !o_tgt[1];
      o_seq_pc   = i_stall ? i_pc : (i_pc + XLEN'(4));
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch-stage PC controller: owns the PC register, applies BCU redirects,
// generates pipeline squash signals, and runs the RUN/HALT/TRAP fetch FSM.
module pc_fetch_ctrl
   import rv_pkg::*;
#(
   parameter int                XLEN     = 32,
   parameter logic [XLEN-1:0]   RESET_PC = '0,
   parameter int                CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic [1:0]       br_flag,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic [XLEN-1:0]  br_target,
   input  logic [XLEN-1:0]  jalr_target,
   input  logic             resume,
   output logic [XLEN-1:0]  pc,
   output logic [XLEN-1:0]  pc_plus4,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             halted,
   output logic             trap,
   output logic [XLEN-1:0]  trap_pc,
   output logic [CNT_W-1:0] redirect_cnt
);

   state_t           r_state;
   state_t           w_state_next;
   logic [XLEN-1:0]  r_pc;
   logic [XLEN-1:0]  w_pc_next;
   logic [XLEN-1:0]  r_trap_pc;
   logic [XLEN-1:0]  w_trap_pc_next;
   logic [CNT_W-1:0] r_cnt;
   logic             w_cnt_inc;
   logic             w_flush;

   logic [XLEN-1:0]  w_tgt;
   logic             w_misalign;
   logic             w_redirect;
   logic [XLEN-1:0]  w_seq_pc;

   pc_next_sel #(
      .XLEN (XLEN)
   ) u_next_sel (
      .i_flag        (br_flag),
      .i_br_target   (br_target),
      .i_jalr_target (jalr_target),
      .i_pc          (r_pc),
      .i_stall       (stall),
      .o_tgt         (w_tgt),
      .o_misalign    (w_misalign),
      .o_redirect    (w_redirect),
      .o_seq_pc      (w_seq_pc)
   );

   // Next-state, next-PC and squash decode; outside RUN everything is frozen and flushed
   always_comb begin
      w_state_next   = r_state;
      w_pc_next      = r_pc;
      w_trap_pc_next = r_trap_pc;
      w_cnt_inc      = 1'b0;
      w_flush        = 1'b1;
      case (r_state)
         RUN: begin
            w_flush = (br_flag != BR_SEQ);
            if (br_flag == BR_SYS) begin
               // halt resumes after the system instruction, not at it
               w_state_next = HALT;
               w_pc_next    = ex_pc + XLEN'(4);
            end else if (w_misalign) begin
               w_state_next   = TRAP;
               w_trap_pc_next = ex_pc;
            end else if (w_redirect) begin
               // redirect wins over stall: the stalled ID instruction is wrong-path
               w_pc_next = w_tgt;
               w_cnt_inc = 1'b1;
            end else begin
               w_pc_next = w_seq_pc;
            end
         end
         HALT: begin
            if (resume) begin
               w_state_next = RUN;
            end
         end
         TRAP: begin
            // sticky until reset
         end
         default: begin
            w_state_next = RUN;
         end
      endcase
   end

   // State, PC, trap PC and saturating redirect counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= RUN;
         r_pc      <= RESET_PC;
         r_trap_pc <= '0;
         r_cnt     <= '0;
      end else begin
         r_state   <= w_state_next;
         r_pc      <= w_pc_next;
         r_trap_pc <= w_trap_pc_next;
         if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
      end
   end

   assign pc           = r_pc;
   assign pc_plus4     = r_pc + XLEN'(4);
   assign if_id_flush  = w_flush;
   assign id_ex_flush  = w_flush;
   assign halted       = (r_state == HALT);
   assign trap         = (r_state == TRAP);
   assign trap_pc      = r_trap_pc;
   assign redirect_cnt = r_cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: a vector table plus hand sequences for
// PC wrap and counter saturation; expected post-edge state goes through a queue.
module tb_pc_fetch_ctrl;

   localparam int CW = 8;

   logic          clk;
   logic          rst;
   logic          stall;
   logic [1:0]    br_flag;
   logic [31:0]   ex_pc;
   logic [31:0]   br_target;
   logic [31:0]   jalr_target;
   logic          resume;
   logic [31:0]   pc;
   logic [31:0]   pc_plus4;
   logic          if_id_flush;
   logic          id_ex_flush;
   logic          halted;
   logic          trap;
   logic [31:0]   trap_pc;
   logic [CW-1:0] redirect_cnt;

   pc_fetch_ctrl #(
      .XLEN     (32),
      .RESET_PC (32'h0),
      .CNT_W    (CW)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .stall        (stall),
      .br_flag      (br_flag),
      .ex_pc        (ex_pc),
      .br_target    (br_target),
      .jalr_target  (jalr_target),
      .resume       (resume),
      .pc           (pc),
      .pc_plus4     (pc_plus4),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .halted       (halted),
      .trap         (trap),
      .trap_pc      (trap_pc),
      .redirect_cnt (redirect_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rst;
      logic          stall;
      logic [1:0]    flag;
      logic [31:0]   ex_pc;
      logic [31:0]   br_t;
      logic [31:0]   jalr_t;
      logic          resume;
      logic          fl_chk;
      logic          exp_fl;
      logic [31:0]   exp_pc;
      logic          exp_h;
      logic          exp_t;
      logic [31:0]   exp_tp;
      logic [CW-1:0] exp_cnt;
   } vec_t;

   vec_t tbl[25];
   vec_t exp_q[$];
   int   n_pass  = 0;
   int   n_total = 0;
   int   n_txn   = 0;

   function automatic vec_t mk(
      input logic r, input logic s, input logic [1:0] f, input logic [31:0] ep,
      input logic [31:0] bt, input logic [31:0] jt, input logic rs,
      input logic fc, input logic fl, input logic [31:0] p, input logic h,
      input logic t, input logic [31:0] tp, input logic [CW-1:0] c);
      vec_t v;
      v.rst = r; v.stall = s; v.flag = f; v.ex_pc = ep; v.br_t = bt; v.jalr_t = jt;
      v.resume = rs; v.fl_chk = fc; v.exp_fl = fl; v.exp_pc = p; v.exp_h = h;
      v.exp_t = t; v.exp_tp = tp; v.exp_cnt = c;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%h required=%h", nm, act, exp);
   endtask

   // One transaction: drive at negedge, check comb flushes, then check registered state after the edge
   task automatic step(input vec_t v);
      vec_t        e;
      logic [31:0] p4;
      @(negedge clk);
      rst = v.rst; stall = v.stall; br_flag = v.flag; ex_pc = v.ex_pc;
      br_target = v.br_t; jalr_target = v.jalr_t; resume = v.resume;
      #1;
      if (v.fl_chk) begin
         chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, v.exp_fl});
         chk("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, v.exp_fl});
      end
      exp_q.push_back(v);
      @(posedge clk);
      #1;
      e  = exp_q.pop_front();
      p4 = e.exp_pc + 32'd4;
      chk("pc", pc, e.exp_pc);
      chk("pc_plus4", pc_plus4, p4);
      chk("halted", {31'd0, halted}, {31'd0, e.exp_h});
      chk("trap", {31'd0, trap}, {31'd0, e.exp_t});
      chk("trap_pc", trap_pc, e.exp_tp);
      chk("redirect_cnt", {{(32-CW){1'b0}}, redirect_cnt}, {{(32-CW){1'b0}}, e.exp_cnt});
      $display("txn %0d rst=%0d flag=%0d stall=%0d resume=%0d -> pc=%h flush=%0d halted=%0d trap=%0d trap_pc=%h cnt=%0d",
               n_txn, e.rst, e.flag, e.stall, e.resume, pc, if_id_flush, halted, trap, trap_pc, redirect_cnt);
      n_txn++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b1; stall = 1'b0; br_flag = 2'b00; ex_pc = '0;
      br_target = '0; jalr_target = '0; resume = 1'b0;

      //            rst s  flag   ex_pc          br_t           jalr_t         rs fc fl exp_pc         h  t  trap_pc        cnt
      tbl[0]  = mk(1, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 0, 0, 32'h0,        0, 0, 32'h0,        0);
      tbl[1]  = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h4,        0, 0, 32'h0,        0);
      tbl[2]  = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h8,        0, 0, 32'h0,        0);
      tbl[3]  = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'hC,        0, 0, 32'h0,        0);
      tbl[4]  = mk(0, 1, 2'b01, 32'h8,        32'h100,      32'h0,        0, 1, 1, 32'h100,      0, 0, 32'h0,        1);
      tbl[5]  = mk(0, 1, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h100,      0, 0, 32'h0,        1);
      tbl[6]  = mk(0, 0, 2'b10, 32'h100,      32'h0,        32'h201,      0, 1, 1, 32'h200,      0, 0, 32'h0,        2);
      tbl[7]  = mk(0, 0, 2'b01, 32'h1F8,      32'h102,      32'h0,        0, 1, 1, 32'h200,      0, 1, 32'h1F8,      2);
      tbl[8]  = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 1, 1, 32'h200,      0, 1, 32'h1F8,      2);
      tbl[9]  = mk(0, 0, 2'b11, 32'h40,       32'h0,        32'h0,        0, 1, 1, 32'h200,      0, 1, 32'h1F8,      2);
      tbl[10] = mk(1, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 1, 32'h0,        0, 0, 32'h0,        0);
      tbl[11] = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h4,        0, 0, 32'h0,        0);
      tbl[12] = mk(0, 0, 2'b10, 32'h1234,     32'h0,        32'h203,      0, 1, 1, 32'h4,        0, 1, 32'h1234,     0);
      tbl[13] = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 1, 1, 32'h4,        0, 1, 32'h1234,     0);
      tbl[14] = mk(1, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 1, 32'h0,        0, 0, 32'h0,        0);
      tbl[15] = mk(0, 0, 2'b11, 32'h40,       32'h0,        32'h0,        1, 1, 1, 32'h44,       1, 0, 32'h0,        0);
      tbl[16] = mk(0, 1, 2'b01, 32'h0,        32'h300,      32'h0,        0, 1, 1, 32'h44,       1, 0, 32'h0,        0);
      tbl[17] = mk(0, 1, 2'b01, 32'h0,        32'h300,      32'h0,        0, 1, 1, 32'h44,       1, 0, 32'h0,        0);
      tbl[18] = mk(0, 0, 2'b10, 32'h0,        32'h0,        32'h300,      0, 1, 1, 32'h44,       1, 0, 32'h0,        0);
      tbl[19] = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 1, 32'h44,       1, 0, 32'h0,        0);
      tbl[20] = mk(0, 0, 2'b11, 32'h80,       32'h0,        32'h0,        0, 1, 1, 32'h44,       1, 0, 32'h0,        0);
      tbl[21] = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        1, 1, 1, 32'h44,       0, 0, 32'h0,        0);
      tbl[22] = mk(0, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h48,       0, 0, 32'h0,        0);
      tbl[23] = mk(0, 0, 2'b11, 32'h80,       32'h0,        32'h0,        0, 1, 1, 32'h84,       1, 0, 32'h0,        0);
      tbl[24] = mk(1, 0, 2'b00, 32'h0,        32'h0,        32'h0,        0, 1, 1, 32'h0,        0, 0, 32'h0,        0);

      for (int i = 0; i < 25; i++) begin
         step(tbl[i]);
      end

      // PC wrap: jump near the top of the address space, then free-run across it
      step(mk(0, 0, 2'b01, 32'h0, 32'hFFFF_FFF8, 32'h0, 0, 1, 1, 32'hFFFF_FFF8, 0, 0, 32'h0, 1));
      step(mk(0, 0, 2'b00, 32'h0, 32'h0,         32'h0, 0, 1, 0, 32'hFFFF_FFFC, 0, 0, 32'h0, 1));
      step(mk(0, 0, 2'b00, 32'h0, 32'h0,         32'h0, 0, 1, 0, 32'h0000_0000, 0, 0, 32'h0, 1));

      // Counter saturation: 2^CW + 3 back-to-back redirects after a reset
      step(mk(1, 0, 2'b00, 32'h0, 32'h0, 32'h0, 0, 1, 0, 32'h0, 0, 0, 32'h0, 0));
      for (int k = 1; k <= (1 << CW) + 3; k++) begin
         logic [CW-1:0] c;
         c = (k >= (1 << CW) - 1) ? {CW{1'b1}} : CW'(k);
         step(mk(0, (k % 3) == 0, 2'b01, 32'h0, 32'h10, 32'h0, 0, 1, 1, 32'h10, 0, 0, 32'h0, c));
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
